// File: rtl/vga_timing_gen_if.sv
// Timing bundle from the VGA timing generator to pixel logic and the connector.
// The generator drives it through the master modport. Consumers read it through the slave modport.
interface vga_timing_gen_if #(
    parameter int CW = 11
);
    logic          pix_ce_o;
    logic          hsync_o;
    logic          vsync_o;
    logic          disp_active;
    logic [CW-1:0] xcol_o;
    logic [CW-1:0] yrow_o;
    logic          line_start_o;
    logic          frame_start_o;

    modport master (
        output pix_ce_o, hsync_o, vsync_o, disp_active,
               xcol_o, yrow_o, line_start_o, frame_start_o
    );

    modport slave (
        input  pix_ce_o, hsync_o, vsync_o, disp_active,
               xcol_o, yrow_o, line_start_o, frame_start_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator running on one system clock.
// A divider produces the pixel clock enable. The decoded timing outputs pass through an optional delay pipe.
module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int CW       = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int PIPE_DLY = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    vga_timing_gen_if.master   vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    // Bounds are one bit wider so a sync pulse ending exactly at 2**CW still compares correctly.
    localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (longint'(H_TOTAL) > (longint'(1) << CW)) begin : g_bad_htotal
            $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
        end
        if (longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_vtotal
            $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
        end
        if (DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: DIV must be at least 1");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_pipe
            $error("vga_timing_gen: PIPE_DLY must be 0..7");
        end
    endgenerate

    typedef struct packed {
        logic          disp;
        logic          hs;
        logic          vs;
        logic          ls;
        logic          fs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } timing_t;

    logic [DW-1:0] div_cnt_reg;
    logic          pix_ce_reg;
    logic          fresh_reg;
    logic          line_wrap_reg;
    logic          frame_wrap_reg;
    logic [CW-1:0] x_reg;
    logic [CW-1:0] y_reg;

    // fresh_reg marks a restarted frame: the first pixel enable starts pixel (0,0) instead of advancing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_reg    <= '0;
            pix_ce_reg     <= 1'b0;
            fresh_reg      <= 1'b1;
            line_wrap_reg  <= 1'b0;
            frame_wrap_reg <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
        end else if (!en_i) begin
            div_cnt_reg    <= '0;
            pix_ce_reg     <= 1'b0;
            fresh_reg      <= 1'b1;
            line_wrap_reg  <= 1'b0;
            frame_wrap_reg <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
        end else begin
            pix_ce_reg     <= (div_cnt_reg == DIV_LAST);
            div_cnt_reg    <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
            line_wrap_reg  <= 1'b0;
            frame_wrap_reg <= 1'b0;
            if (pix_ce_reg) begin
                if (fresh_reg) begin
                    fresh_reg      <= 1'b0;
                    line_wrap_reg  <= 1'b1;
                    frame_wrap_reg <= 1'b1;
                end else if (x_reg == H_LAST) begin
                    x_reg         <= '0;
                    line_wrap_reg <= 1'b1;
                    if (y_reg == V_LAST) begin
                        y_reg          <= '0;
                        frame_wrap_reg <= 1'b1;
                    end else begin
                        y_reg <= y_reg + 1'b1;
                    end
                end else begin
                    x_reg <= x_reg + 1'b1;
                end
            end
        end
    end

    timing_t dec;

    always_comb begin
        dec      = '0;
        dec.x    = x_reg;
        dec.y    = y_reg;
        dec.ls   = line_wrap_reg;
        dec.fs   = frame_wrap_reg;
        dec.disp = !fresh_reg && ({1'b0, x_reg} < H_ACT) && ({1'b0, y_reg} < V_ACT);
        dec.hs   = !fresh_reg && ({1'b0, x_reg} >= HS_BEG) && ({1'b0, x_reg} < HS_END);
        dec.vs   = !fresh_reg && ({1'b0, y_reg} >= VS_BEG) && ({1'b0, y_reg} < VS_END);
    end

    // Stage 0 is the mandatory decode register. Later stages add the alignment delay.
    timing_t stage_reg [0:PIPE_DLY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= dec;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    timing_t pipe_out;
    assign pipe_out = stage_reg[PIPE_DLY];

    assign vga.pix_ce_o      = pix_ce_reg;
    assign vga.hsync_o       = (H_POL != 0) ? pipe_out.hs : ~pipe_out.hs;
    assign vga.vsync_o       = (V_POL != 0) ? pipe_out.vs : ~pipe_out.vs;
    assign vga.disp_active   = pipe_out.disp;
    assign vga.xcol_o        = pipe_out.x;
    assign vga.yrow_o        = pipe_out.y;
    assign vga.line_start_o  = pipe_out.ls;
    assign vga.frame_start_o = pipe_out.fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised enable/reset sequences on a small timing set, checked every clock against a pixel-index model.
module tb_vga_timing_gen;
    localparam int DIV      = 3;
    localparam int CW       = 6;
    localparam int H_ACTIVE = 10;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_POL    = 1;
    localparam int V_POL    = 0;
    localparam int PIPE_DLY = 2;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = HT * VT * DIV;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(CW)) vga_bus ();

    vga_timing_gen #(
        .DIV(DIV), .CW(CW),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL), .PIPE_DLY(PIPE_DLY)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .vga    (vga_bus)
    );

    typedef struct packed {
        logic        run;
        logic [15:0] x;
        logic [15:0] y;
        logic        ls;
        logic        fs;
    } st_t;

    // k = consecutive enabled clock edges since the last restart.
    int  k;
    st_t hist [0:PIPE_DLY+1];

    // Counter state after enabled edge k: pixel enable n lands on edge n*DIV+1 and starts pixel n-1.
    function automatic st_t ideal(input int kk);
        st_t s;
        int  n;
        int  p;
        s = '0;
        n = (kk >= 1) ? (kk - 1) / DIV : 0;
        if (n >= 1) begin
            p     = n - 1;
            s.run = 1'b1;
            s.x   = 16'(p % HT);
            s.y   = 16'((p / HT) % VT);
            s.ls  = ((kk - 1) % DIV == 0) && (s.x == 16'd0);
            s.fs  = s.ls && (s.y == 16'd0);
        end
        return s;
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i <= PIPE_DLY + 1; i++) hist[i] = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic check_outputs();
        st_t  e;
        logic hs_act;
        logic vs_act;
        e      = hist[PIPE_DLY+1];
        hs_act = e.run && (e.x >= H_ACTIVE + H_FP) && (e.x < H_ACTIVE + H_FP + H_SYNC);
        vs_act = e.run && (e.y >= V_ACTIVE + V_FP) && (e.y < V_ACTIVE + V_FP + V_SYNC);
        chk("pix_ce", 32'(vga_bus.pix_ce_o), 32'((k >= DIV) && (k % DIV == 0)));
        chk("hsync", 32'(vga_bus.hsync_o), 32'((H_POL != 0) ? hs_act : !hs_act));
        chk("vsync", 32'(vga_bus.vsync_o), 32'((V_POL != 0) ? vs_act : !vs_act));
        chk("disp_active", 32'(vga_bus.disp_active),
            32'(e.run && (e.x < H_ACTIVE) && (e.y < V_ACTIVE)));
        chk("xcol", 32'(vga_bus.xcol_o), 32'(e.x));
        chk("yrow", 32'(vga_bus.yrow_o), 32'(e.y));
        chk("line_start", 32'(vga_bus.line_start_o), 32'(e.ls));
        chk("frame_start", 32'(vga_bus.frame_start_o), 32'(e.fs));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            k = en ? k + 1 : 0;
            for (int i = PIPE_DLY + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ideal(k);
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt;
        int dcnt;
        int seen;

        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        #2;
        check_outputs();
        run(3);

        // Release and run one frame edge to edge: period and visible-pixel count.
        rst_n = 1'b1;
        en    = 1'b1;
        seen  = 0;
        for (int i = 0; i < 2 * FRAME && seen == 0; i++) begin
            step();
            if (vga_bus.frame_start_o === 1'b1) seen = 1;
        end
        chk("first_frame_start", 32'(seen), 32'd1);
        cnt  = 0;
        dcnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            cnt++;
            if (vga_bus.disp_active === 1'b1) dcnt++;
            if (vga_bus.frame_start_o === 1'b1) break;
        end
        chk("frame_period", 32'(cnt), 32'(FRAME));
        chk("disp_count", 32'(dcnt), 32'(H_ACTIVE * V_ACTIVE * DIV));

        // Random enable bursts, including drops in mid-line and mid-frame.
        for (int seg = 0; seg < 10; seg++) begin
            en = 1'b1;
            run($urandom_range(1, 2 * FRAME));
            en = 1'b0;
            run($urandom_range(1, 6));
        end

        // Asynchronous reset mid-line: outputs must return to reset values without a clock edge.
        en = 1'b1;
        run(FRAME / 2 + 7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        run(2);
        rst_n = 1'b1;

        for (int seg = 0; seg < 4; seg++) begin
            en = 1'b1;
            run($urandom_range(FRAME / 2, FRAME + 40));
            en = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
            run($urandom_range(1, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
